squat_frame_seq: RTL

- Animation sequencer directly upstream of the VGA video generator; drives its `frame_switch` input and a wider frame index.
- Advances the squat animation on vertical-sync boundaries only, so frames never change mid-scan and never tear.
- Two stepping modes:
  - Auto: timed advance, paced by a count of vsync periods.
  - Manual: one step per debounced push-button press.

---
 rtl/squat_frame_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/squat_frame_seq.sv
// squat_frame_seq: animation frame sequencer for the VGA video generator.
// Advances the squat animation only on vsync falling edges, either on a timed
// hold count (auto) or on a debounced push-button press (manual).
// Optional build macro SQUAT_FRAME_PINGPONG_EN: bounce 0..NFRAMES-1..0 instead
// of wrapping NFRAMES-1 -> 0.
module squat_frame_seq #(
  parameter int NFRAMES     = 2,
  parameter int HOLD_FRAMES = 30,
  parameter int DEB_CYCLES  = 250000
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       auto_en,
  input  logic       pause,
  input  logic       step_btn,
  output logic [3:0] frame_idx,
  output logic       frame_switch,
  output logic       frame_start,
  output logic       loop_done
);

  localparam int               DEB_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [3:0]       LAST_IDX  = 4'(NFRAMES - 1);
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD_FRAMES - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {ST_MANUAL, ST_AUTO, ST_PAUSE} state_t;

  state_t           state, state_nxt;
  logic             vsync_q;
  logic             btn_meta, btn_sync, btn_deb;
  logic [DEB_W-1:0] deb_cnt;
  logic             deb_rise;
  logic             step_pending;
  logic [7:0]       hold_cnt, hold_nxt;
  logic             advance, pend_clr;
  logic [3:0]       idx_nxt;
  logic             wrap;
`ifdef SQUAT_FRAME_PINGPONG_EN
  logic             dir_up, dir_nxt;
`endif

  // The debounced level commits high on this cycle: that is a button press.
  assign deb_rise = btn_sync & ~btn_deb & (deb_cnt == DEB_LAST);

  // vsync falling-edge detector; frame_start is registered one cycle after the edge.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      frame_start <= vsync_q & ~vsync;
    end
  end

  // Two-flop synchronizer and stability counter for the raw push button.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      btn_deb  <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_meta <= step_btn;
      btn_sync <= btn_meta;
      if (btn_sync != btn_deb) begin
        if (deb_cnt == DEB_LAST) begin
          btn_deb <= btn_sync;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Mode state register; holds the mode seen on the previous cycle.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) state <= ST_MANUAL;
    else       state <= state_nxt;
  end

  // Mode selection (pause beats auto_en) and the advance decision for this cycle.
  always_comb begin
    state_nxt = ST_MANUAL;
    advance   = 1'b0;
    pend_clr  = 1'b0;
    hold_nxt  = hold_cnt;
    if (pause)        state_nxt = ST_PAUSE;
    else if (auto_en) state_nxt = ST_AUTO;
    case (state_nxt)
      ST_AUTO: begin
        pend_clr = 1'b1;
        if (frame_start) begin
          if (hold_cnt == HOLD_LAST) begin
            advance  = 1'b1;
            hold_nxt = '0;
          end else begin
            hold_nxt = hold_cnt + 8'd1;
          end
        end
      end
      ST_MANUAL: begin
        if (state == ST_AUTO) hold_nxt = '0;
        if (frame_start && step_pending) begin
          advance  = 1'b1;
          pend_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next frame index: plain wrap, or bounce when ping-pong is built in.
  always_comb begin
    idx_nxt = frame_idx;
    wrap    = 1'b0;
`ifdef SQUAT_FRAME_PINGPONG_EN
    dir_nxt = dir_up;
    if (dir_up) idx_nxt = frame_idx + 4'd1;
    else        idx_nxt = frame_idx - 4'd1;
    if (idx_nxt == LAST_IDX) dir_nxt = 1'b0;
    if (idx_nxt == 4'd0) begin
      dir_nxt = 1'b1;
      wrap    = 1'b1;
    end
`else
    if (frame_idx == LAST_IDX) begin
      idx_nxt = 4'd0;
      wrap    = 1'b1;
    end else begin
      idx_nxt = frame_idx + 4'd1;
    end
`endif
  end

  // Pending-step flag and hold counter; a consumed step also swallows a same-cycle press.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      step_pending <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      hold_cnt <= hold_nxt;
      if (pend_clr)      step_pending <= 1'b0;
      else if (deb_rise) step_pending <= 1'b1;
    end
  end

  // Registered frame outputs; frame_switch mirrors bit 0 of the new index.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      frame_idx    <= 4'd0;
      frame_switch <= 1'b0;
      loop_done    <= 1'b0;
`ifdef SQUAT_FRAME_PINGPONG_EN
      dir_up       <= 1'b1;
`endif
    end else begin
      loop_done <= advance & wrap;
      if (advance) begin
        frame_idx    <= idx_nxt;
        frame_switch <= idx_nxt[0];
`ifdef SQUAT_FRAME_PINGPONG_EN
        dir_up       <= dir_nxt;
`endif
      end
    end
  end

endmodule
